reg_wr_decoder: RTL and testbench

Parametrised, registered one-hot write-enable decoder for the register file of the single-cycle CPU. It is the successor to the fixed 3-to-8 combinational decoder and adds four things: a SEL_W-bit select, an enable input, optional masking of register 0 (hardwired zero), and a sequential clear sweep. The sweep walks a one-hot write enable across every register, one per cycle, so the register file can be zeroed after reset or on request. It sits between the control unit / write-back stage and the register file write-enable inputs.

---
 rtl/reg_wr_decoder_pkg.sv | 6 +
 rtl/reg_wr_decoder_onehot_dec.sv | 11 +
 rtl/reg_wr_decoder.sv | 57 +++++
 tb/tb_reg_wr_decoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/reg_wr_decoder_pkg.sv
// reg_wr_decoder_pkg: shared state encoding and select-width limits for the write-enable decoder
package reg_wr_decoder_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;
  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 6;
endpackage

// File: rtl/reg_wr_decoder_onehot_dec.sv
// reg_wr_decoder_onehot_dec: combinational SEL_W-to-2**SEL_W one-hot decoder with enable
module reg_wr_decoder_onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   out
);
  localparam int OUT_W = 2**SEL_W;
  assign out = en ? OUT_W'(1) << sel : '0;
endmodule

// File: rtl/reg_wr_decoder.sv
// reg_wr_decoder: registered one-hot register-file write enable with r0 masking and clear sweep
module reg_wr_decoder
  import reg_wr_decoder_pkg::*;
#(
  parameter int SEL_W          = 3,
  parameter bit ZERO_MASK      = 1,
  parameter bit SWEEP_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sweep_req,
  output logic [2**SEL_W-1:0] out,
  output logic                sweep_active,
  output logic                sweep_done,
  output logic                busy
);
  localparam int OUT_W = 2**SEL_W;
  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel_w
    $error("reg_wr_decoder: SEL_W out of range");
  end
  state_t state, state_nxt;
  logic [SEL_W-1:0] cnt, cnt_nxt, dec_sel;
  logic [OUT_W-1:0] dec_out;
  logic sweep, last, dec_en;
  assign sweep = state == ST_SWEEP;
  assign busy = sweep;
  assign last = cnt == SEL_W'(OUT_W - 1);
  // One decoder serves both paths; a sweep ignores the r0 mask so r0 is cleared too
  always_comb begin
    dec_sel = sweep ? cnt : sel;
    dec_en = sweep || (en && !sweep_req && !(ZERO_MASK && sel == '0));
    state_nxt = sweep ? (last ? ST_IDLE : ST_SWEEP) : (sweep_req ? ST_SWEEP : ST_IDLE);
    cnt_nxt = (sweep && !last) ? cnt + SEL_W'(1) : '0;
  end
  reg_wr_decoder_onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .en (dec_en),
    .sel(dec_sel),
    .out(dec_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SWEEP_ON_RESET ? ST_SWEEP : ST_IDLE;
      cnt <= '0;
      out <= '0;
      sweep_active <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      out <= dec_out;
      sweep_active <= sweep;
      sweep_done <= sweep && last;
    end
  end
endmodule

// File: tb/tb_reg_wr_decoder.sv
// tb_reg_wr_decoder: three configurations driven by shared random stimulus, checked by a queued scoreboard
module tb_reg_wr_decoder;
  localparam int SW0 = 3, SW1 = 5, SW2 = 1;
  localparam bit ZM0 = 1, ZM1 = 0, ZM2 = 1;
  localparam bit SR0 = 1, SR1 = 0, SR2 = 1;
  typedef struct {
    logic [31:0] out;
    logic act;
    logic done;
    logic busy;
  } exp_t;
  logic clk = 0, reset = 1, en = 0, sweep_req = 0;
  logic [4:0] sel_r = '0;
  logic [2**SW0-1:0] out_a;
  logic [2**SW1-1:0] out_b;
  logic [2**SW2-1:0] out_c;
  logic [2:0] act_v, done_v, busy_v;
  logic [31:0] o_v [3];
  int tests = 0, fails = 0;
  int left [3] = '{0, 0, 0};
  exp_t q [3][$];
  always #5 clk = ~clk;
  reg_wr_decoder #(.SEL_W(SW0), .ZERO_MASK(ZM0), .SWEEP_ON_RESET(SR0)) u_a (
    .clk(clk), .reset(reset), .en(en), .sel(sel_r[SW0-1:0]), .sweep_req(sweep_req),
    .out(out_a), .sweep_active(act_v[0]), .sweep_done(done_v[0]), .busy(busy_v[0]));
  reg_wr_decoder #(.SEL_W(SW1), .ZERO_MASK(ZM1), .SWEEP_ON_RESET(SR1)) u_b (
    .clk(clk), .reset(reset), .en(en), .sel(sel_r[SW1-1:0]), .sweep_req(sweep_req),
    .out(out_b), .sweep_active(act_v[1]), .sweep_done(done_v[1]), .busy(busy_v[1]));
  reg_wr_decoder #(.SEL_W(SW2), .ZERO_MASK(ZM2), .SWEEP_ON_RESET(SR2)) u_c (
    .clk(clk), .reset(reset), .en(en), .sel(sel_r[SW2-1:0]), .sweep_req(sweep_req),
    .out(out_c), .sweep_active(act_v[2]), .sweep_done(done_v[2]), .busy(busy_v[2]));
  assign o_v[0] = 32'(out_a);
  assign o_v[1] = 32'(out_b);
  assign o_v[2] = 32'(out_c);
  function automatic int sw_of(int k);
    return k == 0 ? SW0 : k == 1 ? SW1 : SW2;
  endfunction
  function automatic bit zm_of(int k);
    return k == 0 ? ZM0 : k == 1 ? ZM1 : ZM2;
  endfunction
  function automatic bit sr_of(int k);
    return k == 0 ? SR0 : k == 1 ? SR1 : SR2;
  endfunction
  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask
  // Reference: a sweep is a schedule of n pending writes, bit 0 upward; otherwise decode one cycle late
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int n, s;
      exp_t e;
      n = 1 << sw_of(k);
      s = int'(sel_r) % n;
      e = '{out: 32'd0, act: 1'b0, done: 1'b0, busy: 1'b0};
      if (reset) left[k] = sr_of(k) ? n : 0;
      else if (left[k] > 0) begin
        e.out = 32'd1 << (n - left[k]);
        e.act = 1'b1;
        e.done = left[k] == 1;
        left[k]--;
      end else if (sweep_req) left[k] = n;
      else if (en && !(zm_of(k) && s == 0)) e.out = 32'd1 << s;
      e.busy = left[k] > 0;
      q[k].push_back(e);
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (q[k].size() > 0) begin
        exp_t e;
        e = q[k].pop_front();
        chk("out", k, o_v[k], e.out);
        chk("sweep_active", k, 32'(act_v[k]), 32'(e.act));
        chk("sweep_done", k, 32'(done_v[k]), 32'(e.done));
        chk("busy", k, 32'(busy_v[k]), 32'(e.busy));
        chk("onehot0", k, 32'($onehot0(o_v[k])), 32'd1);
      end
    end
  end
  task automatic cyc(bit r, bit e, int s, bit req);
    reset = r;
    en = e;
    sel_r = 5'(s);
    sweep_req = req;
    @(negedge clk);
    #1;
  endtask
  initial begin
    int wait_cnt;
    @(negedge clk);
    #1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 5, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 7, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 1);
    for (int i = 0; i < 40; i++) cyc(0, 1'($urandom), int'($urandom_range(0, 31)), 1'($urandom));
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    wait_cnt = 0;
    while (busy_v[0] && wait_cnt < 50) begin
      cyc(0, 0, 0, 0);
      wait_cnt++;
    end
    tests++;
    if (busy_v[0]) begin
      fails++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy_v[0], wait_cnt);
    end
    cyc(0, 1, 2, 0);
    cyc(0, 1, 6, 0);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 199) == 0, 1'($urandom), int'($urandom_range(0, 31)),
          $urandom_range(0, 39) == 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) chk("drain", k, 32'(q[k].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
